// File: rtl/fp_norm_pack_if.sv
// ---------------------------------------------------------------------------
// fp_norm_pack_if
// Handshake/data bundle between BigALU (upstream), the normalize/pack stage
// and the downstream consumer of the packed IEEE-754 single word.
//
//   in_valid / in_ready    : upstream operand handshake
//   mant_in                : BigALU magnitude (MANT_WIDTH bits, incl. hidden bit)
//   cout_in                : BigALU carry-out
//   sign_in                : BigALU result sign
//   exp_in                 : biased exponent of the larger aligned operand
//   out_valid / out_ready  : result handshake
//   result                 : {sign, exp, fraction}
//   zero_flag / overflow_flag / underflow_flag : result classification
//
// Modports:
//   slave  - view of the normalize/pack stage
//   master - view of the environment driving it (upstream + downstream)
// ---------------------------------------------------------------------------
interface fp_norm_pack_if #(
    parameter int MANT_WIDTH = 24,
    parameter int EXP_WIDTH  = 8
);
    logic                            in_valid;
    logic                            in_ready;
    logic [MANT_WIDTH-1:0]           mant_in;
    logic                            cout_in;
    logic                            sign_in;
    logic [EXP_WIDTH-1:0]            exp_in;
    logic                            out_valid;
    logic                            out_ready;
    logic [EXP_WIDTH+MANT_WIDTH-1:0] result;
    logic                            zero_flag;
    logic                            overflow_flag;
    logic                            underflow_flag;

    modport slave (
        input  in_valid, mant_in, cout_in, sign_in, exp_in, out_ready,
        output in_ready, out_valid, result, zero_flag, overflow_flag, underflow_flag
    );

    modport master (
        output in_valid, mant_in, cout_in, sign_in, exp_in, out_ready,
        input  in_ready, out_valid, result, zero_flag, overflow_flag, underflow_flag
    );
endinterface

// File: rtl/fp_norm_pack.sv
// ---------------------------------------------------------------------------
// fp_norm_pack
// Post-ALU normalization and packing stage. Takes BigALU's magnitude,
// carry-out and sign plus the biased exponent, normalizes the mantissa one
// left shift per clock, and packs an IEEE-754 single-precision word.
// Rounding is truncation; one operation in flight.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - fp_norm_pack_if.slave (operand and result handshakes, flags)
// ---------------------------------------------------------------------------
module fp_norm_pack #(
    parameter int MANT_WIDTH = 24,
    parameter int EXP_WIDTH  = 8
) (
    input  logic           clk,
    input  logic           rst,
    fp_norm_pack_if.slave  bus
);
    localparam int RES_W = EXP_WIDTH + MANT_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_NORM = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    logic [MANT_WIDTH-1:0] r_mant;
    // One extra bit so the carry increment cannot wrap.
    logic [EXP_WIDTH:0]    r_exp;
    logic                  r_sign;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic [RES_W-1:0]      r_result;
    logic                  r_zero;
    logic                  r_ovf;
    logic                  r_unf;

    logic [EXP_WIDTH:0]    w_exp_inc;
    logic [EXP_WIDTH:0]    w_exp_max;
    logic [EXP_WIDTH:0]    w_exp_one;
    logic [RES_W-1:0]      w_ovf_word;
    logic [RES_W-1:0]      w_unf_in_word;

    assign w_exp_inc     = {1'b0, bus.exp_in} + {{EXP_WIDTH{1'b0}}, 1'b1};
    assign w_exp_max     = {1'b0, {EXP_WIDTH{1'b1}}};
    assign w_exp_one     = {{EXP_WIDTH{1'b0}}, 1'b1};
    assign w_ovf_word    = {bus.sign_in, {EXP_WIDTH{1'b1}}, {(MANT_WIDTH-1){1'b0}}};
    assign w_unf_in_word = {bus.sign_in, {(RES_W-1){1'b0}}};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_mant      <= '0;
            r_exp       <= '0;
            r_sign      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_sign     <= bus.sign_in;
                        r_in_ready <= 1'b0;
                        if (bus.cout_in) begin
                            // Carry out: the sum has one extra integer bit,
                            // so shift right once and bump the exponent.
                            if (w_exp_inc >= w_exp_max) begin
                                r_result    <= w_ovf_word;
                                r_ovf       <= 1'b1;
                                r_out_valid <= 1'b1;
                                r_state     <= S_DONE;
                            end else begin
                                r_mant  <= {1'b1, bus.mant_in[MANT_WIDTH-1:1]};
                                r_exp   <= w_exp_inc;
                                r_state <= S_NORM;
                            end
                        end else if (bus.mant_in == '0) begin
                            // Exact cancellation always yields +0.
                            r_result    <= '0;
                            r_zero      <= 1'b1;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else if (&bus.exp_in) begin
                            r_result    <= w_ovf_word;
                            r_ovf       <= 1'b1;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else if (bus.exp_in == '0) begin
                            // Denormal inputs are flushed to signed zero.
                            r_result    <= w_unf_in_word;
                            r_unf       <= 1'b1;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_mant  <= bus.mant_in;
                            r_exp   <= {1'b0, bus.exp_in};
                            r_state <= S_NORM;
                        end
                    end
                end

                S_NORM: begin
                    if (r_mant[MANT_WIDTH-1]) begin
                        // Hidden bit is implicit in the packed word.
                        r_result    <= {r_sign, r_exp[EXP_WIDTH-1:0], r_mant[MANT_WIDTH-2:0]};
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (r_exp == w_exp_one) begin
                        // Another shift would need exponent 0: flush.
                        r_result    <= {r_sign, {(RES_W-1){1'b0}}};
                        r_unf       <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_mant <= {r_mant[MANT_WIDTH-2:0], 1'b0};
                        r_exp  <= r_exp - w_exp_one;
                    end
                end

                S_DONE: begin
                    // Result and flags hold until the consumer takes them;
                    // the handoff edge never also accepts a new operand.
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_zero      <= 1'b0;
                        r_ovf       <= 1'b0;
                        r_unf       <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready       = r_in_ready;
    assign bus.out_valid      = r_out_valid;
    assign bus.result         = r_result;
    assign bus.zero_flag      = r_zero;
    assign bus.overflow_flag  = r_ovf;
    assign bus.underflow_flag = r_unf;
endmodule
